// File: rtl/serial_word_deser_if.sv
// Bundles the serial bit input, the word valid/ready output and the status signals
// of serial_word_deser.
interface serial_word_deser_if #(
  parameter int unsigned Width = 8
) ();
  localparam int unsigned CntW = (Width > 1) ? $clog2(Width) : 1;

  logic            bit_in;
  logic            bit_valid;
  logic [Width-1:0] word_out;
  logic            word_valid;
  logic            word_ready;
  logic [CntW-1:0] bit_cnt;
  logic            overrun;

  // Producer of bits and consumer of words.
  modport master (
    output bit_in,
    output bit_valid,
    output word_ready,
    input  word_out,
    input  word_valid,
    input  bit_cnt,
    input  overrun
  );

  // The deserializer itself.
  modport slave (
    input  bit_in,
    input  bit_valid,
    input  word_ready,
    output word_out,
    output word_valid,
    output bit_cnt,
    output overrun
  );
endinterface

// File: rtl/serial_word_deser.sv
// Serial-to-parallel deserializer with a one-word holding register on a valid/ready
// output and a sticky overrun flag for words dropped under backpressure.
module serial_word_deser #(
  parameter int unsigned Width    = 8,
  parameter bit          MsbFirst = 1'b1
) (
  input logic                 clk_i,
  input logic                 rst_ni,
  serial_word_deser_if.slave  bus_io
);
  localparam int unsigned CntW = (Width > 1) ? $clog2(Width) : 1;

  logic [Width-1:0] shift_q, shift_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [Width-1:0] word_q, word_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;

  logic             complete;
  logic             accept;
  logic [Width-1:0] shifted;

  // Collector never stalls; the shifted value doubles as the completed word.
  always_comb begin
    shifted  = shift_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    complete = 1'b0;
    if (MsbFirst) begin
      shifted = {shift_q[Width-2:0], bus_io.bit_in};
    end else begin
      shifted = {bus_io.bit_in, shift_q[Width-1:1]};
    end
    if (bus_io.bit_valid) begin
      shift_d = shifted;
      if (cnt_q == CntW'(Width - 1)) begin
        complete = 1'b1;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_comb begin
    accept    = valid_q & bus_io.word_ready;
    word_d    = word_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    if (complete) begin
      if (!valid_q || accept) begin
        word_d  = shifted;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (accept) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shift_q   <= '0;
      cnt_q     <= '0;
      word_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      word_q    <= word_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign bus_io.word_out   = word_q;
  assign bus_io.word_valid = valid_q;
  assign bus_io.bit_cnt    = cnt_q;
  assign bus_io.overrun    = overrun_q;
endmodule

// File: tb/tb_serial_word_deser.sv
// Drives an MSB-first and an LSB-first deserializer with the same bit stream and
// checks both against a queue-based model of word assembly and output holding.
module tb_serial_word_deser;
  localparam int unsigned Width = 8;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  logic bit_in = 1'b0;
  logic bit_valid = 1'b0;
  logic word_ready = 1'b0;

  int n_tests = 0;
  int n_fail = 0;

  always #5 clk_i = ~clk_i;

  serial_word_deser_if #(.Width(Width)) bus_m ();
  serial_word_deser_if #(.Width(Width)) bus_l ();

  assign bus_m.bit_in     = bit_in;
  assign bus_m.bit_valid  = bit_valid;
  assign bus_m.word_ready = word_ready;
  assign bus_l.bit_in     = bit_in;
  assign bus_l.bit_valid  = bit_valid;
  assign bus_l.word_ready = word_ready;

  serial_word_deser #(.Width(Width), .MsbFirst(1'b1)) u_dut_msb (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus_io (bus_m)
  );

  serial_word_deser #(.Width(Width), .MsbFirst(1'b0)) u_dut_lsb (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus_io (bus_l)
  );

  // Reference model: index 0 is the MSB-first device, 1 the LSB-first device.
  bit               q[$];
  logic [Width-1:0] m_word[2];
  logic             m_valid[2];
  logic             m_ovr[2];

  function automatic logic [Width-1:0] pack(input bit msb_first);
    logic [Width-1:0] w;
    w = '0;
    for (int i = 0; i < int'(Width); i++) begin
      if (msb_first) w[int'(Width) - 1 - i] = q[i];
      else           w[i] = q[i];
    end
    return w;
  endfunction

  task automatic model_reset();
    q.delete();
    for (int d = 0; d < 2; d++) begin
      m_word[d]  = '0;
      m_valid[d] = 1'b0;
      m_ovr[d]   = 1'b0;
    end
  endtask

  task automatic model_edge();
    bit done;
    bit acc;
    done = 1'b0;
    if (bit_valid) begin
      q.push_back(bit_in);
      if (q.size() == int'(Width)) done = 1'b1;
    end
    for (int d = 0; d < 2; d++) begin
      acc = m_valid[d] && word_ready;
      if (done) begin
        if (!m_valid[d] || acc) begin
          m_word[d]  = pack(d == 0);
          m_valid[d] = 1'b1;
        end else begin
          m_ovr[d] = 1'b1;
        end
      end else if (acc) begin
        m_valid[d] = 1'b0;
      end
    end
    if (done) q.delete();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("msb_valid", 32'(bus_m.word_valid), 32'(m_valid[0]));
    chk("msb_word", 32'(bus_m.word_out), 32'(m_word[0]));
    chk("msb_cnt", 32'(bus_m.bit_cnt), 32'(q.size()));
    chk("msb_ovr", 32'(bus_m.overrun), 32'(m_ovr[0]));
    chk("lsb_valid", 32'(bus_l.word_valid), 32'(m_valid[1]));
    chk("lsb_word", 32'(bus_l.word_out), 32'(m_word[1]));
    chk("lsb_cnt", 32'(bus_l.bit_cnt), 32'(q.size()));
    chk("lsb_ovr", 32'(bus_l.overrun), 32'(m_ovr[1]));
  endtask

  // Drive inputs, take one edge, sample 1 time unit later.
  task automatic step(input logic v, input logic b, input logic r);
    bit_valid  = v;
    bit_in     = b;
    word_ready = r;
    @(posedge clk_i);
    model_edge();
    #1;
    check_all();
  endtask

  // Sends bits w[7]..w[first_bits-... ] in transmission order, first nbits bits only.
  task automatic feed(input logic [Width-1:0] w, input int nbits, input logic r,
                      input bit gaps);
    for (int i = 0; i < nbits; i++) begin
      step(1'b1, w[int'(Width) - 1 - i], r);
      if (gaps) step(1'b0, 1'b0, r);
    end
  endtask

  initial begin
    model_reset();
    #1;
    check_all();
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Bit order, consumer always ready.
    feed(8'hD0, 8, 1'b1, 1'b0);
    chk("order_msb", 32'(bus_m.word_out), 32'h0000_00D0);
    chk("order_lsb", 32'(bus_l.word_out), 32'h0000_000B);
    chk("order_valid", 32'(bus_m.word_valid), 32'd1);
    step(1'b0, 1'b0, 1'b1);
    chk("order_pulse", 32'(bus_m.word_valid), 32'd0);

    // Gapped input.
    feed(8'hD0, 7, 1'b1, 1'b1);
    chk("gap_cnt", 32'(bus_m.bit_cnt), 32'd7);
    chk("gap_novalid", 32'(bus_m.word_valid), 32'd0);
    feed(8'hD0 << 7, 1, 1'b1, 1'b0);
    chk("gap_word", 32'(bus_m.word_out), 32'h0000_00D0);
    step(1'b0, 1'b0, 1'b1);

    // Backpressure, overrun, release.
    feed(8'hD0, 8, 1'b0, 1'b0);
    feed(8'hA5, 7, 1'b0, 1'b0);
    chk("bp_word", 32'(bus_m.word_out), 32'h0000_00D0);
    chk("bp_valid", 32'(bus_m.word_valid), 32'd1);
    chk("bp_ovr", 32'(bus_m.overrun), 32'd0);
    chk("bp_cnt", 32'(bus_m.bit_cnt), 32'd7);
    step(1'b1, 1'b1, 1'b0);
    chk("ovr_set", 32'(bus_m.overrun), 32'd1);
    chk("ovr_word", 32'(bus_m.word_out), 32'h0000_00D0);
    step(1'b0, 1'b0, 1'b1);
    chk("ovr_accept", 32'(bus_m.word_valid), 32'd0);
    chk("ovr_sticky", 32'(bus_m.overrun), 32'd1);

    // Accept and completion on the same edge.
    feed(8'hD0, 8, 1'b0, 1'b0);
    feed(8'h5A, 7, 1'b0, 1'b0);
    feed(8'h5A << 7, 1, 1'b1, 1'b0);
    chk("simul_word", 32'(bus_m.word_out), 32'h0000_005A);
    chk("simul_valid", 32'(bus_m.word_valid), 32'd1);
    chk("simul_ovr", 32'(bus_m.overrun), 32'd1);

    // Asynchronous reset mid-word.
    step(1'b0, 1'b0, 1'b1);
    feed(8'hFF, 5, 1'b0, 1'b0);
    #2;
    rst_ni = 1'b0;
    model_reset();
    #1;
    check_all();
    chk("rst_ovr", 32'(bus_m.overrun), 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    feed(8'h3C, 8, 1'b0, 1'b0);
    chk("rst_word", 32'(bus_m.word_out), 32'h0000_003C);
    step(1'b0, 1'b0, 1'b1);

    // Random traffic with varying backpressure.
    for (int i = 0; i < 400; i++) begin
      step(logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 1)),
           logic'($urandom_range(0, 2) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/serial_word_deser.md
# serial_word_deser

Serial-to-parallel deserializer that sits directly downstream of the single-bit registered data stage. It collects qualified serial bits into WIDTH-bit words and presents each completed word on a valid/ready output port. A one-word holding register decouples bit collection from the consumer, and a sticky flag reports words lost to backpressure.

## Interface
- WIDTH, 8, word width in bits (2..32)
- MSB_FIRST, 1, 1: first received bit lands in word_out[WIDTH-1]; 0: first bit lands in word_out[0]

- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- bit_in  in  1  serial data bit (registered bit from the upstream stage)
- bit_valid  in  1  bit_in is captured on a rising edge where bit_valid=1
- word_out  out  WIDTH  completed word; stable while word_valid=1 and not accepted
- word_valid  out  1  holding register holds an unconsumed word
- word_ready  in  1  consumer accepts word_out on an edge where word_valid=1 and word_ready=1
- bit_cnt  out  $clog2(WIDTH)  number of bits collected toward the current word (0..WIDTH-1)
- overrun  out  1  sticky; set when a completed word is dropped

## Operation
- Reset (rst=0, any time, asynchronous): shift register, bit_cnt, word_out, word_valid, overrun all cleared to 0. A partial word in progress is discarded; no word is emitted from it after reset releases.
- Collection: each edge with bit_valid=1 shifts bit_in into the shift register and increments bit_cnt. MSB_FIRST=1 shifts left (new bit into LSB); MSB_FIRST=0 shifts right (new bit into MSB). Edges with bit_valid=0 change nothing in the collector.
- Completion: the edge capturing the WIDTH-th bit (bit_cnt=WIDTH-1 and bit_valid=1) forms the word from the shift register plus the current bit_in and wraps bit_cnt to 0. The collector never stalls; bits keep being accepted every cycle regardless of output state.
- Output holding register, evaluated on each edge with accept = word_valid & word_ready:
  - completion and (word_valid=0 or accept): load new word into word_out, word_valid=1.
  - completion and word_valid=1 and no accept: new word dropped, word_out unchanged, overrun set to 1.
  - no completion and accept: word_valid=0; word_out holds last value.
  - otherwise: hold.
- overrun clears only on reset.
- word_ready is ignored when word_valid=0.

## Timing
- Latency: word_valid rises on the same edge that captures the last bit; word_out is valid in the cycle immediately after that edge.
- Throughput: one word per WIDTH bit_valid cycles, sustained, as long as the consumer accepts within WIDTH cycles of presentation.
- Back-to-back: with word_ready held 1 and bit_valid held 1, word_valid pulses high for exactly one cycle every WIDTH cycles.
- Simultaneous accept and completion on one edge: no gap; word_valid stays 1 and word_out takes the new word on that edge.
- word_out and word_valid never change while word_valid=1 and word_ready=0, except through reset.
- bit_cnt reflects the count after each edge; it reads 0 both after reset and after each completion.

## Test plan
- Reset mid-word: WIDTH=8; feed 5 bits, assert rst=0 between edges -> bit_cnt, word_valid, overrun read 0 immediately; then 8 more bits produce exactly one word made of those 8 bits only.
- Bit order: WIDTH=8, word_ready=1; bits 1,1,0,1,0,0,0,0 on consecutive edges -> MSB_FIRST=1: word_out=0xD0; MSB_FIRST=0: word_out=0x0B; word_valid high for one cycle after the 8th edge.
- Gapped input: the same 8 bits with bit_valid=0 inserted between each bit -> same word; bit_cnt holds during gaps; word_valid rises only on the 8th valid edge.
- Backpressure hold: word_ready=0 after word 0xD0 completes; feed 7 more bits -> word_out=0xD0 and word_valid=1 held; overrun=0; bit_cnt=7.
- Overrun: continue the previous case with an 8th bit while word_ready=0 -> overrun=1, word_out still 0xD0; raise word_ready -> 0xD0 accepted, word_valid=0, overrun stays 1.
- Simultaneous accept and complete: word_ready rises on exactly the edge the next word (0x5A) completes -> old word accepted, word_out=0x5A, word_valid stays 1, overrun unchanged.
